parking_occupancy_counter: RTL and testbench

PARKING_OCCUPANCY_COUNTER -- requirements
Module: parking_occupancy_counter

---
 rtl/parking_occupancy_counter.sv | 212 +++++++++++++++++++++
 tb/tb_parking_occupancy_counter.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_occupancy_counter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// parking_occupancy_counter
//
// Purpose:
//   Counts the cars parked in a car park with CAPACITY slots. An entry is
//   counted when a car has passed the entrance gate. The entry FSM tracks the
//   gate opening and the car crossing sensor_out. An exit is counted on the
//   rising edge of the (optionally debounced) exit-lane sensor. Occupancy
//   saturates at both ends and raises sticky error flags.
//
// Configuration macro:
//   PARK_EXIT_DEBOUNCE_EN - when defined, exit_sensor must be high for
//                           DEBOUNCE_CYC consecutive samples before it counts.
//
// Parameters:
//   CAPACITY     - number of parking slots (1..255)
//   CNT_W        - width of the count outputs (must hold CAPACITY)
//   DEBOUNCE_CYC - exit-sensor stable cycles (used only with the macro)
//
// Ports:
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-low reset
//   gate_state      in   entrance gate open (1)
//   sensor_out      in   car present beyond the entrance gate
//   exit_sensor     in   car present in the exit lane
//   err_clr         in   clears ovf_err / unf_err (a new error wins)
//   occupancy       out  cars currently parked
//   free_slots      out  CAPACITY - occupancy
//   full / empty    out  occupancy == CAPACITY / occupancy == 0
//   entry_enable    out  !full, qualifies the gate controller
//   car_entered     out  one-cycle pulse per counted entry
//   car_exited      out  one-cycle pulse per counted exit
//   ovf_err         out  sticky: entry seen while full
//   unf_err         out  sticky: exit seen while empty
//   dbg_entry_state out  entry FSM state (0 idle, 1 gate, 2 pass)
//
// Interface semantics: there is no valid/ready handshake here. Every input
// is sampled level-wise on each rising clk edge. The outputs car_entered and
// car_exited are single-cycle events and need no acknowledge.
// -----------------------------------------------------------------------------
module parking_occupancy_counter #(
    parameter int CAPACITY     = 8,
    parameter int CNT_W        = 4,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gate_state,
    input  logic             sensor_out,
    input  logic             exit_sensor,
    input  logic             err_clr,
    output logic [CNT_W-1:0] occupancy,
    output logic [CNT_W-1:0] free_slots,
    output logic             full,
    output logic             empty,
    output logic             entry_enable,
    output logic             car_entered,
    output logic             car_exited,
    output logic             ovf_err,
    output logic             unf_err,
    output logic [1:0]       dbg_entry_state
);

    // Elaboration-time guard against parameter sets the counter cannot represent.
    if (CAPACITY < 1 || CAPACITY > 255 || CAPACITY >= (1 << CNT_W) || DEBOUNCE_CYC < 1) begin : g_param_check
        $error("parking_occupancy_counter: illegal CAPACITY/CNT_W/DEBOUNCE_CYC");
    end

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_GATE = 2'd1,
        E_PASS = 2'd2
    } entry_state_t;

    entry_state_t     entry_state;
    entry_state_t     entry_next;
    logic             entry_done;   // E_PASS -> E_IDLE this cycle
    logic             exit_qual;    // exit sensor after optional debounce
    logic             exit_q;       // edge-detect register for exit_qual
    logic             exit_rise;
    logic [CNT_W-1:0] occ_next;
    logic             ovf_set;
    logic             unf_set;

    // ------------------------------------------------------------------
    // Entry FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_state <= E_IDLE;
        end else begin
            entry_state <= entry_next;
        end
    end

    always_comb begin
        entry_next = entry_state;
        entry_done = 1'b0;
        case (entry_state)
            // sensor_out is ignored here: a car can only count after the gate opened.
            E_IDLE: begin
                if (gate_state) begin
                    entry_next = E_GATE;
                end
            end
            // Gate closing before the car reaches sensor_out means it turned back.
            E_GATE: begin
                if (!gate_state) begin
                    entry_next = E_IDLE;
                end else if (sensor_out) begin
                    entry_next = E_PASS;
                end
            end
            // Once past the gate the car is committed; the gate may close behind it.
            E_PASS: begin
                if (!sensor_out) begin
                    entry_next = E_IDLE;
                    entry_done = 1'b1;
                end
            end
            default: begin
                entry_next = E_IDLE;
            end
        endcase
    end

    assign dbg_entry_state = entry_state;

    // ------------------------------------------------------------------
    // Exit qualification
    // ------------------------------------------------------------------
`ifdef PARK_EXIT_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);

    logic [DEB_W-1:0] deb_cnt;

    // Counts consecutive high samples and saturates at DEBOUNCE_CYC. Any low
    // sample restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_cnt <= '0;
        end else if (!exit_sensor) begin
            deb_cnt <= '0;
        end else if (deb_cnt != DEB_W'(DEBOUNCE_CYC)) begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign exit_qual = (deb_cnt == DEB_W'(DEBOUNCE_CYC));
`else
    assign exit_qual = exit_sensor;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exit_q <= 1'b0;
        end else begin
            exit_q <= exit_qual;
        end
    end

    assign exit_rise = exit_qual & ~exit_q;

    // ------------------------------------------------------------------
    // Occupancy update. A simultaneous entry and exit cancel out, so neither
    // boundary check applies to that pair.
    // ------------------------------------------------------------------
    always_comb begin
        occ_next = occupancy;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (entry_done && !exit_rise) begin
            if (occupancy == CAP) begin
                ovf_set = 1'b1;
            end else begin
                occ_next = occupancy + 1'b1;
            end
        end else if (exit_rise && !entry_done) begin
            if (occupancy == '0) begin
                unf_set = 1'b1;
            end else begin
                occ_next = occupancy - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupancy   <= '0;
            car_entered <= 1'b0;
            car_exited  <= 1'b0;
            ovf_err     <= 1'b0;
            unf_err     <= 1'b0;
        end else begin
            occupancy   <= occ_next;
            car_entered <= entry_done;
            car_exited  <= exit_rise;
            // A new error in the same cycle as err_clr stays set.
            ovf_err     <= ovf_set | (ovf_err & ~err_clr);
            unf_err     <= unf_set | (unf_err & ~err_clr);
        end
    end

    assign full         = (occupancy == CAP);
    assign empty        = (occupancy == '0);
    assign free_slots   = CAP - occupancy;
    assign entry_enable = ~full;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_parking_occupancy_counter
//
// Drives car entries, turn-backs, exits, simultaneous entry/exit pairs, error
// clears and resets. The reference model is a plain integer car count with
// sticky error bits, updated per completed car movement.
// -----------------------------------------------------------------------------
module tb_parking_occupancy_counter;

    localparam int CAPACITY     = 8;
    localparam int CNT_W        = 4;
    localparam int DEBOUNCE_CYC = 4;

`ifdef PARK_EXIT_DEBOUNCE_EN
    localparam int EXIT_LAT = DEBOUNCE_CYC + 1;  // cycles from exit rise to car_exited
    localparam int MIN_LEN  = DEBOUNCE_CYC;      // shortest exit pulse that counts
`else
    localparam int EXIT_LAT = 1;
    localparam int MIN_LEN  = 1;
`endif

    logic             clk;
    logic             reset;
    logic             gate_state;
    logic             sensor_out;
    logic             exit_sensor;
    logic             err_clr;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] free_slots;
    logic             full;
    logic             empty;
    logic             entry_enable;
    logic             car_entered;
    logic             car_exited;
    logic             ovf_err;
    logic             unf_err;
    logic [1:0]       dbg_entry_state;

    int checks = 0;
    int errors = 0;

    // Reference model: cars parked and the two sticky flags.
    int model_occ = 0;
    bit model_ovf = 1'b0;
    bit model_unf = 1'b0;

    logic [CNT_W-1:0] exp_q[$];

    parking_occupancy_counter #(
        .CAPACITY    (CAPACITY),
        .CNT_W       (CNT_W),
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .gate_state     (gate_state),
        .sensor_out     (sensor_out),
        .exit_sensor    (exit_sensor),
        .err_clr        (err_clr),
        .occupancy      (occupancy),
        .free_slots     (free_slots),
        .full           (full),
        .empty          (empty),
        .entry_enable   (entry_enable),
        .car_entered    (car_entered),
        .car_exited     (car_exited),
        .ovf_err        (ovf_err),
        .unf_err        (unf_err),
        .dbg_entry_state(dbg_entry_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- model helpers ----------------
    task automatic model_entry();
        if (model_occ == CAPACITY) model_ovf = 1'b1;
        else model_occ++;
    endtask

    task automatic model_exit();
        if (model_occ == 0) model_unf = 1'b1;
        else model_occ--;
    endtask

    // ---------------- driver tasks ----------------
    // Full entry: gate opens, car reaches sensor_out, car clears sensor_out.
    task automatic drive_entry(input int gate_dwell, input int pass_dwell, input bit gate_close_early);
        gate_state = 1'b1;
        tick();
        for (int i = 0; i < gate_dwell; i++) tick();
        sensor_out = 1'b1;
        tick();
        for (int i = 0; i < pass_dwell; i++) begin
            if (gate_close_early && i == 0) gate_state = 1'b0;
            tick();
            checks++;
            if (car_entered !== 1'b0) begin
                errors++;
                $display("FAIL entry_early_pulse: car_entered=%b required 0", car_entered);
            end
        end
        sensor_out = 1'b0;
        gate_state = 1'b0;
        tick();
        model_entry();
        checks++;
        if (car_entered !== 1'b1 || occupancy !== CNT_W'(model_occ)) begin
            errors++;
            $display("FAIL entry_pulse: car_entered=%b occupancy=%0d required 1/%0d",
                     car_entered, occupancy, model_occ);
        end
        tick();
        checks++;
        if (car_entered !== 1'b0) begin
            errors++;
            $display("FAIL entry_pulse_width: car_entered=%b required 0", car_entered);
        end
    endtask

    // Gate opens and closes without the car reaching sensor_out.
    task automatic drive_abort(input int dwell);
        gate_state = 1'b1;
        sensor_out = 1'b0;
        for (int i = 0; i < dwell; i++) tick();
        gate_state = 1'b0;
        tick();
        tick();
        checks++;
        if (car_entered !== 1'b0 || occupancy !== CNT_W'(model_occ)) begin
            errors++;
            $display("FAIL abort: car_entered=%b occupancy=%0d required 0/%0d",
                     car_entered, occupancy, model_occ);
        end
    endtask

    // exit_sensor high for len cycles; a qualified exit pulses EXIT_LAT cycles after the rise.
    task automatic drive_exit(input int len);
        int n;
        bit exp_pulse;
        n = (len > EXIT_LAT) ? len : EXIT_LAT;
        for (int i = 1; i <= n + 2; i++) begin
            exit_sensor = (i <= len);
            tick();
            exp_pulse = (len >= MIN_LEN) && (i == EXIT_LAT);
            if (exp_pulse) model_exit();
            checks++;
            if (car_exited !== exp_pulse || occupancy !== CNT_W'(model_occ)) begin
                errors++;
                $display("FAIL exit len=%0d cyc=%0d: car_exited=%b occupancy=%0d required %b/%0d",
                         len, i, car_exited, occupancy, exp_pulse, model_occ);
            end
        end
        exit_sensor = 1'b0;
    endtask

    // Entry completion and exit event land on the same clock edge.
    task automatic drive_simul();
        gate_state = 1'b1;
        tick();
        sensor_out = 1'b1;
        tick();
        exit_sensor = 1'b1;
        for (int i = 1; i < EXIT_LAT; i++) tick();
        sensor_out = 1'b0;
        gate_state = 1'b0;
        tick();
        checks++;
        if (car_entered !== 1'b1 || car_exited !== 1'b1 || occupancy !== CNT_W'(model_occ)) begin
            errors++;
            $display("FAIL simultaneous: entered=%b exited=%b occupancy=%0d required 1/1/%0d",
                     car_entered, car_exited, occupancy, model_occ);
        end
        exit_sensor = 1'b0;
        tick();
        tick();
        checks++;
        if (car_entered !== 1'b0 || car_exited !== 1'b0 || ovf_err !== model_ovf || unf_err !== model_unf) begin
            errors++;
            $display("FAIL simultaneous_after: entered=%b exited=%b ovf=%b unf=%b required 0/0/%b/%b",
                     car_entered, car_exited, ovf_err, unf_err, model_ovf, model_unf);
        end
    endtask

    task automatic drive_err_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        model_ovf = 1'b0;
        model_unf = 1'b0;
    endtask

    // sensor_out toggles while no gate cycle is in progress.
    task automatic drive_idle_noise(input int n);
        for (int i = 0; i < n; i++) begin
            sensor_out = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (car_entered !== 1'b0) begin
                errors++;
                $display("FAIL idle_noise: car_entered=%b required 0", car_entered);
            end
        end
        sensor_out = 1'b0;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset       = 1'b1;
        gate_state  = 1'b0;
        sensor_out  = 1'b0;
        exit_sensor = 1'b0;
        err_clr     = 1'b0;
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (occupancy !== 0 || free_slots !== CNT_W'(CAPACITY) || empty !== 1'b1 || full !== 1'b0 ||
            entry_enable !== 1'b1 || car_entered !== 1'b0 || car_exited !== 1'b0 ||
            ovf_err !== 1'b0 || unf_err !== 1'b0 || dbg_entry_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: occ=%0d free=%0d empty=%b full=%b en=%b ce=%b cx=%b ovf=%b unf=%b st=%0d",
                     occupancy, free_slots, empty, full, entry_enable, car_entered, car_exited,
                     ovf_err, unf_err, dbg_entry_state);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_normal_entry();
        drive_entry(1, 2, 1'b0);
        checks++;
        if (occupancy !== 1 || free_slots !== CNT_W'(CAPACITY - 1) || empty !== 1'b0) begin
            errors++;
            $display("FAIL normal_entry: occ=%0d free=%0d empty=%b required 1/%0d/0",
                     occupancy, free_slots, empty, CAPACITY - 1);
        end
    endtask

    task automatic test_abort();
        drive_abort(3);
        checks++;
        if (occupancy !== CNT_W'(model_occ) || ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_occ: occ=%0d ovf=%b required %0d/0", occupancy, ovf_err, model_occ);
        end
    endtask

    task automatic test_fill_overflow();
        while (model_occ < CAPACITY) drive_entry(0, 1, 1'b0);
        checks++;
        if (full !== 1'b1 || entry_enable !== 1'b0 || free_slots !== 0 || occupancy !== CNT_W'(CAPACITY)) begin
            errors++;
            $display("FAIL fill: full=%b en=%b free=%0d occ=%0d required 1/0/0/%0d",
                     full, entry_enable, free_slots, occupancy, CAPACITY);
        end
        drive_entry(1, 0, 1'b0);
        checks++;
        if (occupancy !== CNT_W'(CAPACITY) || ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL overflow: occ=%0d ovf=%b required %0d/1", occupancy, ovf_err, CAPACITY);
        end
        drive_err_clr();
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b required 0", ovf_err);
        end
        // err_clr on the same edge as a new overflow: the overflow stays set.
        gate_state = 1'b1;
        tick();
        sensor_out = 1'b1;
        tick();
        sensor_out = 1'b0;
        gate_state = 1'b0;
        err_clr    = 1'b1;
        tick();
        err_clr = 1'b0;
        model_entry();
        checks++;
        if (ovf_err !== 1'b1 || occupancy !== CNT_W'(CAPACITY)) begin
            errors++;
            $display("FAIL ovf_set_wins: ovf=%b occ=%0d required 1/%0d", ovf_err, occupancy, CAPACITY);
        end
        drive_err_clr();
    endtask

    task automatic test_simultaneous();
        while (model_occ > 3) drive_exit(MIN_LEN + 1);
        drive_simul();
        checks++;
        if (occupancy !== 3) begin
            errors++;
            $display("FAIL simul_at_3: occ=%0d required 3", occupancy);
        end
        while (model_occ > 0) drive_exit(MIN_LEN);
        drive_simul();
        checks++;
        if (occupancy !== 0 || unf_err !== 1'b0 || ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL simul_at_0: occ=%0d unf=%b ovf=%b required 0/0/0", occupancy, unf_err, ovf_err);
        end
    endtask

    task automatic test_underflow();
        drive_exit(MIN_LEN);
        checks++;
        if (unf_err !== 1'b1 || occupancy !== 0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow: unf=%b occ=%0d empty=%b required 1/0/1", unf_err, occupancy, empty);
        end
        drive_err_clr();
        checks++;
        if (unf_err !== 1'b0) begin
            errors++;
            $display("FAIL unf_clear: unf=%b required 0", unf_err);
        end
    endtask

    task automatic test_exit_qualify();
        drive_entry(0, 0, 1'b0);
        drive_entry(2, 1, 1'b1);
`ifdef PARK_EXIT_DEBOUNCE_EN
        drive_exit(3);   // glitch, must not count
        drive_exit(6);   // counts once
`else
        drive_exit(1);
        drive_exit(4);
`endif
        checks++;
        if (occupancy !== CNT_W'(model_occ)) begin
            errors++;
            $display("FAIL exit_qualify: occ=%0d required %0d", occupancy, model_occ);
        end
    endtask

    task automatic test_idle_noise();
        drive_idle_noise(12);
        checks++;
        if (occupancy !== CNT_W'(model_occ)) begin
            errors++;
            $display("FAIL idle_noise_occ: occ=%0d required %0d", occupancy, model_occ);
        end
    endtask

    task automatic test_reset_mid_entry();
        drive_entry(0, 1, 1'b0);
        drive_entry(1, 1, 1'b0);
        gate_state = 1'b1;
        tick();
        sensor_out = 1'b1;
        tick();               // FSM now tracking a car past the gate
        #2 reset = 1'b0;
        #1;
        model_occ = 0;
        model_ovf = 1'b0;
        model_unf = 1'b0;
        checks++;
        if (occupancy !== 0 || free_slots !== CNT_W'(CAPACITY) || empty !== 1'b1 || full !== 1'b0 ||
            entry_enable !== 1'b1 || car_entered !== 1'b0 || dbg_entry_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_entry: occ=%0d free=%0d empty=%b full=%b en=%b ce=%b st=%0d",
                     occupancy, free_slots, empty, full, entry_enable, car_entered, dbg_entry_state);
        end
        tick();
        gate_state = 1'b0;
        sensor_out = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (car_entered !== 1'b0 || occupancy !== 0) begin
                errors++;
                $display("FAIL reset_discard: ce=%b occ=%0d required 0/0", car_entered, occupancy);
            end
        end
    endtask

    task automatic test_random();
        logic [CNT_W-1:0] exp_occ;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: drive_entry($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                3:       drive_abort($urandom_range(1, 3));
                4, 5:    drive_exit($urandom_range(1, MIN_LEN + 3));
                6:       drive_simul();
                default: begin
                    if ($urandom_range(0, 1) == 0) drive_err_clr();
                    else drive_idle_noise($urandom_range(1, 4));
                end
            endcase
            exp_q.push_back(CNT_W'(model_occ));
            exp_occ = exp_q.pop_front();
            checks++;
            if (occupancy !== exp_occ || free_slots !== CNT_W'(CAPACITY - model_occ) ||
                full !== (model_occ == CAPACITY) || empty !== (model_occ == 0) ||
                entry_enable !== (model_occ != CAPACITY) ||
                ovf_err !== model_ovf || unf_err !== model_unf) begin
                errors++;
                $display("FAIL random op=%0d: occ=%0d free=%0d full=%b empty=%b en=%b ovf=%b unf=%b required occ=%0d ovf=%b unf=%b",
                         n, occupancy, free_slots, full, empty, entry_enable, ovf_err, unf_err,
                         exp_occ, model_ovf, model_unf);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_normal_entry();
        test_abort();
        test_fill_overflow();
        test_simultaneous();
        test_underflow();
        test_exit_qualify();
        test_idle_noise();
        test_reset_mid_entry();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
